// File: rtl/chimera_cluster_pwr_seq_if.sv
// Handshake bundle between the SoC register file / cluster power cells and
// the cluster power sequencer. The sequencer is the slave: it consumes the
// request vector and isolate acknowledges, and drives the per-cluster
// clock-gate, reset and isolate controls plus status.
interface chimera_cluster_pwr_seq_if #(
    parameter int unsigned NumClusters = 5
);
    localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

    logic [NumClusters-1:0] en_req_i;
    logic [NumClusters-1:0] iso_ack_i;
    logic [NumClusters-1:0] clu_clk_en_o;
    logic [NumClusters-1:0] clu_rst_no;
    logic [NumClusters-1:0] clu_iso_o;
    logic [NumClusters-1:0] enabled_o;
    logic                   busy_o;
    logic [IdxW-1:0]        cur_idx_o;

    modport master (
        output en_req_i,
        output iso_ack_i,
        input  clu_clk_en_o,
        input  clu_rst_no,
        input  clu_iso_o,
        input  enabled_o,
        input  busy_o,
        input  cur_idx_o
    );

    modport slave (
        input  en_req_i,
        input  iso_ack_i,
        output clu_clk_en_o,
        output clu_rst_no,
        output clu_iso_o,
        output enabled_o,
        output busy_o,
        output cur_idx_o
    );
endinterface

// File: rtl/chimera_cluster_pwr_seq.sv
// Chimera cluster power sequencer. Arbitrates pending power-state changes
// round-robin and walks one cluster at a time through a fixed ordered
// handshake: clock enable -> reset release -> de-isolation on the way up,
// isolation -> reset assertion -> clock gating on the way down.
module chimera_cluster_pwr_seq #(
    parameter int unsigned NumClusters     = 5,
    parameter int unsigned ClkSettleCycles = 4,
    parameter int unsigned RstHoldCycles   = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    chimera_cluster_pwr_seq_if.slave      bus
);
    localparam int unsigned IdxW      = (NumClusters > 1) ? $clog2(NumClusters) : 1;
    localparam int unsigned MaxCycles = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles
                                                                          : RstHoldCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] ClkSettleLoad = CntW'(ClkSettleCycles);
    localparam logic [CntW-1:0] RstHoldLoad   = CntW'(RstHoldCycles);
    localparam logic [CntW-1:0] CntOne        = CntW'(1);
    localparam logic [IdxW-1:0] LastIdx       = IdxW'(NumClusters - 1);
    localparam logic [IdxW:0]   NumWide       = (IdxW + 1)'(NumClusters);

    typedef enum logic [2:0] {
        IDLE,
        UP_CLK,
        UP_RST,
        UP_DEISO,
        DN_ISO,
        DN_RST
    } state_e;

    state_e                 state_reg;
    logic [CntW-1:0]        cnt_reg;
    logic [IdxW-1:0]        ptr_reg;
    logic [IdxW-1:0]        cur_idx_reg;
    logic [NumClusters-1:0] clk_en_reg;
    logic [NumClusters-1:0] rst_n_reg;
    logic [NumClusters-1:0] iso_reg;
    logic [NumClusters-1:0] enabled_reg;
    logic                   busy_reg;

    // A cluster needs work whenever its requested state differs from the
    // state it has been fully sequenced into.
    logic [NumClusters-1:0] pending;
    assign pending = bus.en_req_i ^ enabled_reg;

    // Candidate gi is the cluster gi positions after the round-robin pointer,
    // wrapped into range; cand_hit flags whether that candidate is pending.
    logic [IdxW-1:0]        cand_idx [NumClusters];
    logic [NumClusters-1:0] cand_hit;

    for (genvar gi = 0; gi < NumClusters; gi++) begin : g_cand
        logic [IdxW:0] sum;
        assign sum          = {1'b0, ptr_reg} + (IdxW + 1)'(gi);
        assign cand_idx[gi] = (sum >= NumWide) ? IdxW'(sum - NumWide) : sum[IdxW-1:0];
        assign cand_hit[gi] = pending[cand_idx[gi]];
    end

    // Pick the nearest pending candidate at or after the pointer; scanning
    // from the far end lets the closest hit overwrite the farther ones.
    logic            grant_valid;
    logic [IdxW-1:0] grant_idx;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = NumClusters - 1; i >= 0; i--) begin
            if (cand_hit[i]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx[i];
            end
        end
    end

    // Sequencer FSM: owns every output register. Only bits of the latched
    // cluster index are ever written, so idle clusters hold their state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            ptr_reg     <= '0;
            cur_idx_reg <= '0;
            clk_en_reg  <= '0;
            rst_n_reg   <= '0;
            iso_reg     <= '1;
            enabled_reg <= '0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        cur_idx_reg <= grant_idx;
                        busy_reg    <= 1'b1;
                        ptr_reg     <= (grant_idx == LastIdx) ? '0 : grant_idx + 1'b1;
                        if (bus.en_req_i[grant_idx]) begin
                            clk_en_reg[grant_idx] <= 1'b1;
                            cnt_reg               <= ClkSettleLoad;
                            state_reg             <= UP_CLK;
                        end else begin
                            iso_reg[grant_idx]     <= 1'b1;
                            enabled_reg[grant_idx] <= 1'b0;
                            state_reg              <= DN_ISO;
                        end
                    end
                end

                UP_CLK: begin
                    if (cnt_reg == CntOne) begin
                        cnt_reg   <= RstHoldLoad;
                        state_reg <= UP_RST;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                UP_RST: begin
                    if (cnt_reg == CntOne) begin
                        rst_n_reg[cur_idx_reg] <= 1'b1;
                        iso_reg[cur_idx_reg]   <= 1'b0;
                        state_reg              <= UP_DEISO;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                UP_DEISO: begin
                    if (!bus.iso_ack_i[cur_idx_reg]) begin
                        enabled_reg[cur_idx_reg] <= 1'b1;
                        busy_reg                 <= 1'b0;
                        cur_idx_reg              <= '0;
                        state_reg                <= IDLE;
                    end
                end

                DN_ISO: begin
                    if (bus.iso_ack_i[cur_idx_reg]) begin
                        rst_n_reg[cur_idx_reg] <= 1'b0;
                        cnt_reg                <= RstHoldLoad;
                        state_reg              <= DN_RST;
                    end
                end

                DN_RST: begin
                    if (cnt_reg == CntOne) begin
                        clk_en_reg[cur_idx_reg] <= 1'b0;
                        busy_reg                <= 1'b0;
                        cur_idx_reg             <= '0;
                        state_reg               <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.clu_clk_en_o = clk_en_reg;
    assign bus.clu_rst_no   = rst_n_reg;
    assign bus.clu_iso_o    = iso_reg;
    assign bus.enabled_o    = enabled_reg;
    assign bus.busy_o       = busy_reg;
    assign bus.cur_idx_o    = cur_idx_reg;

endmodule
